// File: rtl/bti_pkg.sv
// Shared helpers for the BTI interconnect blocks.
//   bti_id_w(n) : bits needed to index n items, never less than 1.
package bti_pkg;

    localparam int unsigned BTI_AW_DEF = 32;
    localparam int unsigned BTI_DW_DEF = 32;

    // Index width for n items; a single item still gets one bit.
    function automatic int unsigned bti_id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bti_arb_id_fifo.sv
// In-order FIFO of host IDs for requests the guest has accepted but not answered.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   push, id_in      : enqueue id_in (ignored when full)
//   pop              : dequeue head (ignored when empty)
//   head_id          : oldest outstanding ID
//   full, empty      : occupancy flags
module bti_arb_id_fifo
    import bti_pkg::*;
#(
    parameter int unsigned ID_W  = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] id_in,
    input  logic            pop,
    output logic [ID_W-1:0] head_id,
    output logic            full,
    output logic            empty
);

    localparam int unsigned IDX_W = bti_id_w(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [ID_W-1:0]  mem [DEPTH];

    // Storage index is the pointer without its wrap bit; a single entry always sits at 0.
    generate
        if (DEPTH == 1) begin : g_one
            assign wr_idx = '0;
            assign rd_idx = '0;
        end else begin : g_many
            assign wr_idx = wr_ptr[IDX_W-1:0];
            assign rd_idx = rd_ptr[IDX_W-1:0];
        end
    endgenerate

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
    assign head_id = mem[rd_idx];

    // Pointer update; a pop never frees room for a same-cycle push (full is pre-pop).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_idx] <= id_in;
    end

endmodule

// File: rtl/bti_arb.sv
// Merges HOST_NUM BTI host ports onto one BTI guest port and routes in-order
// responses back to the issuing host.
// Configuration: define BTI_ARB_RR_EN for round-robin; otherwise fixed
// priority (lowest index wins).
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   host_bti_req_slvs_*        : per-host request (vld/addr/wr/wdata/wstrb in, rdy out)
//   host_bti_rsp_msts_*        : per-host response (vld/rdata out, rdy in)
//   gst_bti_req_mst_*          : merged guest request (vld/payload out, rdy in)
//   gst_bti_rsp_slv_*          : guest response (vld/rdata in, rdy out)
module bti_arb
    import bti_pkg::*;
#(
    parameter int unsigned BTI_AW   = BTI_AW_DEF,
    parameter int unsigned BTI_DW   = BTI_DW_DEF,
    parameter int unsigned HOST_NUM = 2,
    parameter int unsigned OSTD_NUM = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [HOST_NUM-1:0]                 host_bti_req_slvs_vld,
    output logic [HOST_NUM-1:0]                 host_bti_req_slvs_rdy,
    input  logic [HOST_NUM-1:0][BTI_AW-1:0]     host_bti_req_slvs_addr,
    input  logic [HOST_NUM-1:0]                 host_bti_req_slvs_wr,
    input  logic [HOST_NUM-1:0][BTI_DW-1:0]     host_bti_req_slvs_wdata,
    input  logic [HOST_NUM-1:0][BTI_DW/8-1:0]   host_bti_req_slvs_wstrb,
    output logic [HOST_NUM-1:0]                 host_bti_rsp_msts_vld,
    input  logic [HOST_NUM-1:0]                 host_bti_rsp_msts_rdy,
    output logic [HOST_NUM-1:0][BTI_DW-1:0]     host_bti_rsp_msts_rdata,
    output logic                                gst_bti_req_mst_vld,
    input  logic                                gst_bti_req_mst_rdy,
    output logic [BTI_AW-1:0]                   gst_bti_req_mst_addr,
    output logic                                gst_bti_req_mst_wr,
    output logic [BTI_DW-1:0]                   gst_bti_req_mst_wdata,
    output logic [BTI_DW/8-1:0]                 gst_bti_req_mst_wstrb,
    input  logic                                gst_bti_rsp_slv_vld,
    output logic                                gst_bti_rsp_slv_rdy,
    input  logic [BTI_DW-1:0]                   gst_bti_rsp_slv_rdata
);

    localparam int unsigned     ID_W    = bti_id_w(HOST_NUM);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(HOST_NUM - 1);

    logic            lock;
    logic [ID_W-1:0] lock_id;
    logic [ID_W-1:0] start_id;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] cand_id;
    logic            found;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] head_id;
    logic            fifo_full;
    logic            fifo_empty;
    logic            req_hs;
    logic            rsp_hs;

`ifdef BTI_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr;

    // Search starts one past the most recently accepted host.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (req_hs)
            rr_ptr <= (grant == LAST_ID) ? '0 : grant + ID_W'(1);
    end

    assign start_id = rr_ptr;
`else
    assign start_id = '0;
`endif

    // First valid host at or after start_id, wrapping modulo HOST_NUM.
    always_comb begin
        pick_id = start_id;
        cand_id = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < HOST_NUM; i++) begin
            cand_id = ID_W'((32'(start_id) + i) % HOST_NUM);
            if (!found && host_bti_req_slvs_vld[cand_id]) begin
                pick_id = cand_id;
                found   = 1'b1;
            end
        end
    end

    // A stalled guest request keeps its host so the payload cannot change under it.
    assign grant = lock ? lock_id : pick_id;

    assign gst_bti_req_mst_vld   = host_bti_req_slvs_vld[grant] && !fifo_full;
    assign gst_bti_req_mst_addr  = host_bti_req_slvs_addr[grant];
    assign gst_bti_req_mst_wr    = host_bti_req_slvs_wr[grant];
    assign gst_bti_req_mst_wdata = host_bti_req_slvs_wdata[grant];
    assign gst_bti_req_mst_wstrb = host_bti_req_slvs_wstrb[grant];
    assign req_hs                = gst_bti_req_mst_vld && gst_bti_req_mst_rdy;

    // Only the granted host sees ready.
    always_comb begin
        host_bti_req_slvs_rdy        = '0;
        host_bti_req_slvs_rdy[grant] = gst_bti_req_mst_rdy && !fifo_full;
    end

    // Lock tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock    <= 1'b0;
            lock_id <= '0;
        end else if (req_hs) begin
            lock    <= 1'b0;
        end else if (gst_bti_req_mst_vld) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end
    end

    bti_arb_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (OSTD_NUM)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (req_hs),
        .id_in   (grant),
        .pop     (rsp_hs),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Response routing to the oldest outstanding host.
    always_comb begin
        host_bti_rsp_msts_vld = '0;
        gst_bti_rsp_slv_rdy   = 1'b0;
        if (!fifo_empty) begin
            host_bti_rsp_msts_vld[head_id] = gst_bti_rsp_slv_vld;
            gst_bti_rsp_slv_rdy            = host_bti_rsp_msts_rdy[head_id];
        end
    end

    assign rsp_hs                  = gst_bti_rsp_slv_vld && gst_bti_rsp_slv_rdy;
    assign host_bti_rsp_msts_rdata = {HOST_NUM{gst_bti_rsp_slv_rdata}};

endmodule

// File: doc/bti_arb.md
# bti_arb

Round-robin arbiter that merges `HOST_NUM` BTI host ports onto one BTI guest port: the many-to-one counterpart of the BTI demux. It lets several initiators share one guest, for example an instruction fetch port and a DMA sharing the ITCM read side. It tracks up to `OSTD_NUM` accepted requests so that in-order responses return to the host that issued them.

## Interface
Parameters:
- `BTI_AW`, 32: address width.
- `BTI_DW`, 32: data width.
- `HOST_NUM`, 2: number of host ports; must be ≥2.
- `OSTD_NUM`, 2: maximum requests accepted by the guest but not yet answered; power of two, ≥1.

Ports (clock and reset first):
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `host_bti_req_slvs`, slave, `bti_req_if_t[HOST_NUM]`: host requests. Fields: `vld`, `rdy`, `addr`, `wr`, `wdata`, `wstrb`.
- `host_bti_rsp_msts`, master, `bti_rsp_if_t[HOST_NUM]`: host responses. Fields: `vld`, `rdy`, `rdata`.
- `gst_bti_req_mst`, master, `bti_req_if_t`: merged request to the guest.
- `gst_bti_rsp_slv`, slave, `bti_rsp_if_t`: guest response.

## Operation
- **Handshake.** A transfer happens when `vld && rdy` in the same cycle. Once a master raises `vld`, it holds `vld` and the payload stable until `rdy`.
- **Arbitration.**
  - `grant` is a combinational pick among valid hosts. The search starts at `rr_ptr` and wraps modulo `HOST_NUM`.
  - `rr_ptr` advances to granted+1 (wrapping) on each guest request handshake. It is unchanged otherwise.
- **Lock.**
  - If guest `req.vld` was asserted with `rdy` low, `lock` is set and `lock_id` holds the grant. While `lock` is set, grant is forced to `lock_id`.
  - `lock` clears on the handshake. This guarantees payload stability toward the guest.
- **Request path.**
  - Guest `req.vld` = `vld` of the granted host AND NOT `fifo_full`.
  - The payload is muxed from the granted host.
  - Granted host `req.rdy` = guest `req.rdy` AND NOT `fifo_full`. All other hosts see `rdy` = 0.
- **ID FIFO.**
  - Each guest request handshake pushes the granted ID.
  - Each guest response handshake pops it.
  - Depth is `OSTD_NUM`. Pointers are `log2(OSTD_NUM)+1` bits with wrap bit: full when indices are equal and wrap bits differ; empty when pointers are equal.
- **Response path.**
  - When the FIFO is non-empty, host `head_id` `rsp.vld` = guest `rsp.vld`, and guest `rsp.rdy` = that host's `rsp.rdy`. `rdata` is broadcast to all hosts.
  - When the FIFO is empty, guest `rsp.rdy` = 0 and all host `rsp.vld` = 0.
- **Boundaries.**
  - Push and pop in the same cycle: allowed when not full; occupancy unchanged.
  - When full, no push occurs even if a pop happens in the same cycle (no bypass). The next push occurs the following cycle.
  - Responses are in order; the guest never reorders.
- **Reset.** `rr_ptr` = 0, `lock` = 0, and FIFO pointers = 0. As a result all host `rdy`/`vld` and guest `vld`/`rdy` are 0 until inputs assert. Reset mid-transaction discards outstanding IDs; hosts and the guest must be reset together.

## Timing
- Request: zero-cycle combinational path from host to guest. Grant and lock updates take effect the next cycle.
- Response: zero-cycle routing through registered `head_id`. The guest responds no earlier than the cycle after the request handshake; a same-cycle response is stalled (`rdy` = 0).
- Throughput: one request per cycle when `OSTD_NUM` ≥ guest latency+1. With `OSTD_NUM` = 1, request and response alternate, with a one-cycle bubble after each pop.

## Configuration
- **`BTI_ARB_RR_EN` defined:** round-robin behaviour as above.
- **Undefined:** fixed priority; the lowest index wins. `rr_ptr` is removed and the search always starts at 0. The lock behaviour is unchanged.

## Structure
- **`bti_pkg`:** the `bti_id_w(n)` function (`$clog2`, min 1).
- **`bti_arb_id_fifo`:** sub-module with `clk`, `rst_n`, `push`/`id_in`, `pop`, `head_id`, `full`, `empty`, and parameters `ID_W`, `DEPTH`.

## Test plan
- **Single host:** host0 reads `0x100`, guest returns `0xDEADBEEF` next cycle → host0 `rsp.vld` with `0xDEADBEEF`; host1 `rsp.vld` stays 0.
- **Contention:** both hosts are valid continuously for 4 requests with `BTI_ARB_RR_EN` → guest order is 0,1,0,1. Without the macro → 0,0,0,0 until host0 drops.
- **Lock:** guest `rdy` is held low for 3 cycles while host0 is granted and host1 is valid → guest payload is stable; host0 is accepted on cycle 4, then host1.
- **Full:** `OSTD_NUM` = 2, guest withholds responses → the third request sees `rdy` = 0. When a response is popped, the third is accepted the following cycle.
- **Routing:** host1 then host0 requests, guest responds `0x11`, `0x22` → host1 gets `0x11`, host0 gets `0x22`. Host1 `rsp.rdy` low for 2 cycles stalls guest `rsp.rdy`.
- **Reset:** `rst_n` low with 2 outstanding → after reset, FIFO is empty, guest `rsp.rdy` = 0, and `rr_ptr` = 0.
